// File: rtl/tca9539_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tca9539_pkg                                                    |
// | Purpose  : Shared types and constants for the TCA9539 behavioural model: |
// |            register command enum, I2C front-end FSM state enum, and the  |
// |            default upper address bits.                                   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package tca9539_pkg;

  // Fixed upper five bits of the 7-bit target address.
  localparam logic [4:0] DEFAULT_ADDR_BASE = 5'b11101;

  // Register index carried by the command byte; shared with the register file.
  typedef enum logic [2:0] {
    INPUT_PORT_0              = 3'd0,
    INPUT_PORT_1              = 3'd1,
    OUTPUT_PORT_0             = 3'd2,
    OUTPUT_PORT_1             = 3'd3,
    POLARITY_INVERSION_PORT_0 = 3'd4,
    POLARITY_INVERSION_PORT_1 = 3'd5,
    CONFIGURATION_PORT_0      = 3'd6,
    CONFIGURATION_PORT_1      = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    CMD       = 4'd3,
    CMD_ACK   = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_LOAD   = 4'd7,
    RD_DATA   = 4'd8,
    RD_ACK    = 4'd9,
    WAIT_STOP = 4'd10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tca9539_i2c_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tca9539_i2c_slave_if                                          |
// | Purpose  : Register-access interface between the I2C front-end and the   |
// |            TCA9539 register file.                                        |
// | Signals  : reg_addr[2:0]    current command pointer                      |
// |            reg_wr_en        one-clk write strobe                         |
// |            reg_wr_data[7:0] write data, valid with reg_wr_en             |
// |            reg_rd_data[7:0] combinational read of register[reg_addr]     |
// |            reg_rd_strobe    one-clk pulse when a read byte is loaded     |
// | Modports : master = I2C front-end, slave = register file                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface tca9539_i2c_slave_if;
  logic [2:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       reg_rd_strobe;

  modport master (
    output reg_addr,
    output reg_wr_en,
    output reg_wr_data,
    output reg_rd_strobe,
    input  reg_rd_data
  );

  modport slave (
    input  reg_addr,
    input  reg_wr_en,
    input  reg_wr_data,
    input  reg_rd_strobe,
    output reg_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/i2c_line_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_line_cond                                                 |
// | Purpose  : Synchronises raw scl/sda, optionally filters them, and        |
// |            produces scl edge strobes plus START/STOP detection.          |
// | Macro    : TCA9539_GLITCH_FILTER_EN - adds a 3-sample stability filter   |
// |            per line (pulses of 2 clk or less are rejected).              |
// | Ports    : clk, reset_n (sync, active-low), scl_raw, sda_raw             |
// |            sda_level - conditioned sda                                   |
// |            scl_rise/scl_fall/start_det/stop_det - one-clk strobes        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_clean;
  logic                   sda_clean;
  logic                   scl_prev;
  logic                   sda_prev;

  // Idle bus level is high, so the chains reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
    end
  end

`ifdef TCA9539_GLITCH_FILTER_EN
  logic [2:0] scl_hist;
  logic [2:0] sda_hist;

  // Output follows the line only once three consecutive samples agree.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_hist  <= 3'b111;
      sda_hist  <= 3'b111;
      scl_clean <= 1'b1;
      sda_clean <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
      if ((scl_hist == 3'b000 || scl_hist == 3'b111) && scl_hist[0] != scl_clean)
        scl_clean <= scl_hist[0];
      if ((sda_hist == 3'b000 || sda_hist == 3'b111) && sda_hist[0] != sda_clean)
        sda_clean <= sda_hist[0];
    end
  end
`else
  assign scl_clean = scl_sync[SYNC_STAGES-1];
  assign sda_clean = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_clean;
      sda_prev <= sda_clean;
    end
  end

  assign sda_level = sda_clean;
  assign scl_rise  = scl_clean & ~scl_prev;
  assign scl_fall  = ~scl_clean & scl_prev;
  // scl must be high on both samples so an sda change racing an scl edge
  // is not mistaken for a bus condition.
  assign start_det = scl_clean & scl_prev & sda_prev & ~sda_clean;
  assign stop_det  = scl_clean & scl_prev & ~sda_prev & sda_clean;

endmodule
`default_nettype wire

// File: rtl/tca9539_i2c_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tca9539_i2c_slave                                             |
// | Purpose  : I2C target front-end for the TCA9539 model. Oversamples       |
// |            scl/sda on clk, decodes address/command/data and drives the   |
// |            register-access interface.                                    |
// | Macro    : TCA9539_GLITCH_FILTER_EN (see i2c_line_cond)                  |
// | Ports    : clk, reset_n (sync, active-low)                               |
// |            scl, sda_in - raw bus lines; sda_oe - 1 pulls sda low         |
// |            a0, a1 - address select; busy - addressed transfer active     |
// |            reg_if - register-access interface (master side)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tca9539_i2c_slave
  import tca9539_pkg::*;
#(
  parameter logic [4:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       scl,
  input  logic                       sda_in,
  output logic                       sda_oe,
  input  logic                       a0,
  input  logic                       a1,
  output logic                       busy,
  tca9539_i2c_slave_if.master        reg_if
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_raw   (scl),
    .sda_raw   (sda_in),
    .sda_level (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic       phase, phase_nxt;     // ACK: sda held; RD_ACK: controller ACK seen
  logic       rw, rw_nxt;
  logic       sda_oe_nxt, busy_nxt;
  logic [2:0] addr_q, addr_nxt;
  logic       wr_en_q, wr_en_nxt;
  logic [7:0] wr_data_q, wr_data_nxt;
  logic [7:0] byte_in;

  assign byte_in = {shift[6:0], sda};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      phase     <= 1'b0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      addr_q    <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      phase     <= phase_nxt;
      rw        <= rw_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      addr_q    <= addr_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_data_q <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    phase_nxt   = phase;
    rw_nxt      = rw;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    addr_nxt    = addr_q;
    wr_en_nxt   = 1'b0;
    wr_data_nxt = wr_data_q;

    // Bus conditions take priority over any scl edge in the same clk.
    if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
      phase_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 3'd0;
      sda_oe_nxt  = 1'b0;
      phase_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shift_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_in[7:1] == {ADDR_BASE, a1, a0}) begin
              state_nxt = ADDR_ACK;
              busy_nxt  = 1'b1;
              rw_nxt    = byte_in[0];
            end else begin
              state_nxt = WAIT_STOP;
            end
          end
        end
        // First fall pulls sda low, second fall (one scl period later) releases.
        ADDR_ACK, CMD_ACK, WR_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_oe_nxt = 1'b1;
            phase_nxt  = 1'b1;
          end else begin
            sda_oe_nxt = 1'b0;
            phase_nxt  = 1'b0;
            if (state == ADDR_ACK) begin
              state_nxt = rw ? RD_LOAD : CMD;
            end else if (state == CMD_ACK) begin
              state_nxt = WR_DATA;
            end else begin
              state_nxt   = WR_DATA;
              addr_nxt[0] = ~addr_q[0];
            end
          end
        end
        CMD: if (scl_rise) begin
          shift_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            addr_nxt  = byte_in[2:0];
            state_nxt = CMD_ACK;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            wr_en_nxt   = 1'b1;
            wr_data_nxt = byte_in;
            state_nxt   = WR_ACK;
          end
        end
        // Entered one clk after an scl fall, so the MSB goes out immediately;
        // the remaining seven bits follow from the shift register.
        RD_LOAD: begin
          sda_oe_nxt  = ~reg_if.reg_rd_data[7];
          shift_nxt   = {reg_if.reg_rd_data[6:0], 1'b0};
          addr_nxt[0] = ~addr_q[0];
          bit_cnt_nxt = 3'd0;
          state_nxt   = RD_DATA;
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            phase_nxt   = 1'b0;
            state_nxt   = RD_ACK;
          end else begin
            sda_oe_nxt  = ~shift[7];
            shift_nxt   = {shift[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda) state_nxt = WAIT_STOP;
            else     phase_nxt = 1'b1;
          end else if (scl_fall && phase) begin
            phase_nxt = 1'b0;
            state_nxt = RD_LOAD;
          end
        end
        default: sda_oe_nxt = 1'b0;  // IDLE, WAIT_STOP
      endcase
    end
  end

  assign reg_if.reg_addr      = addr_q;
  assign reg_if.reg_wr_en     = wr_en_q;
  assign reg_if.reg_wr_data   = wr_data_q;
  // Decoded from state so the strobe coincides with the address being read.
  assign reg_if.reg_rd_strobe = (state == RD_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_tca9539_i2c_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tca9539_i2c_slave                                          |
// | Purpose  : Directed self-checking bench for tca9539_i2c_slave.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tca9539_i2c_slave;
  localparam int Q = 100;  // quarter-ish scl phase, 10 clk

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, scl, ctrl_sda, a0, a1;
  logic sda_oe, busy, sda_bus;
  logic [7:0] rd_mem [0:7];

  int vectors = 0;
  int miscompares = 0;

  assign sda_bus = ctrl_sda & ~sda_oe;

  tca9539_i2c_slave_if rif();
  assign rif.reg_rd_data = rd_mem[rif.reg_addr];

  tca9539_i2c_slave dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl     (scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .a0      (a0),
    .a1      (a1),
    .busy    (busy),
    .reg_if  (rif)
  );

  int wr_cnt = 0, strobe_cnt = 0, oe_cnt = 0;
  logic [2:0] wr_a [0:63];
  logic [7:0] wr_d [0:63];

  always @(negedge clk) begin
    if (rif.reg_wr_en) begin
      if (wr_cnt < 64) begin
        wr_a[wr_cnt] = rif.reg_addr;
        wr_d[wr_cnt] = rif.reg_wr_data;
      end
      wr_cnt++;
    end
    if (rif.reg_rd_strobe) strobe_cnt++;
    if (sda_oe) oe_cnt++;
  end

  // ---------------- bus controller ----------------
  task automatic i2c_start;
    ctrl_sda = 1'b1; #Q; scl = 1'b1; #Q; ctrl_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    ctrl_sda = 1'b0; #Q; scl = 1'b1; #Q; ctrl_sda = 1'b1; #Q;
  endtask

  task automatic put_bit(input logic b);
    ctrl_sda = b; #Q; scl = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    ctrl_sda = 1'b1; #Q; scl = 1'b1; #(Q/2); b = sda_bus; #(Q/2); scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] d);
    logic [7:0] t;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      t[i] = b;
    end
    d = t;
    put_bit(nack);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0; #(Q);
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (rif.reg_addr !== 3'd0) begin miscompares++; $display("FAIL reset_reg_addr got %0d want 0", rif.reg_addr); end
    vectors++; if (rif.reg_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", rif.reg_wr_en); end
    vectors++; if (rif.reg_wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data got %h want 00", rif.reg_wr_data); end
    vectors++; if (rif.reg_rd_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_rd_strobe got %b want 0", rif.reg_rd_strobe); end
    reset_n = 1'b1; #(Q);
  endtask

  task automatic test_write;
    int base;
    logic ack [4];
    logic [2:0] ea [2];
    logic [7:0] ed [2];
    ea = '{3'd6, 3'd7};
    ed = '{8'h00, 8'hFF};
    base = wr_cnt;
    i2c_start;
    put_byte(8'hE8, ack[0]);
    put_byte(8'h06, ack[1]);
    put_byte(8'h00, ack[2]);
    put_byte(8'hFF, ack[3]);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy_mid got %b want 1", busy); end
    i2c_stop; #(Q);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (ack[i] !== 1'b0) begin miscompares++; $display("FAIL write_ack%0d got %b want 0", i, ack[i]); end
    end
    vectors++; if (wr_cnt - base !== 2) begin miscompares++; $display("FAIL write_count got %0d want 2", wr_cnt - base); end
    for (int i = 0; i < 2; i++) if (base + i < wr_cnt) begin
      vectors++;
      if (wr_a[base+i] !== ea[i] || wr_d[base+i] !== ed[i]) begin
        miscompares++; $display("FAIL write_entry%0d got (%0d,%h) want (%0d,%h)", i, wr_a[base+i], wr_d[base+i], ea[i], ed[i]);
      end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_after got %b want 0", busy); end
    vectors++; if (rif.reg_addr !== 3'd6) begin miscompares++; $display("FAIL write_ptr got %0d want 6", rif.reg_addr); end
  endtask

  task automatic test_read;
    int sbase;
    logic ack [3];
    logic [7:0] b0, b1;
    sbase = strobe_cnt;
    i2c_start;
    put_byte(8'hE8, ack[0]);
    put_byte(8'h00, ack[1]);
    i2c_start;
    put_byte(8'hE9, ack[2]);
    get_byte(1'b0, b0);
    get_byte(1'b1, b1);
    i2c_stop; #(Q);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ack[i] !== 1'b0) begin miscompares++; $display("FAIL read_ack%0d got %b want 0", i, ack[i]); end
    end
    vectors++; if (b0 !== 8'hA5) begin miscompares++; $display("FAIL read_byte0 got %h want a5", b0); end
    vectors++; if (b1 !== 8'h3C) begin miscompares++; $display("FAIL read_byte1 got %h want 3c", b1); end
    vectors++; if (strobe_cnt - sbase !== 2) begin miscompares++; $display("FAIL read_strobes got %0d want 2", strobe_cnt - sbase); end
    vectors++; if (rif.reg_addr !== 3'd0) begin miscompares++; $display("FAIL read_ptr got %0d want 0", rif.reg_addr); end
  endtask

  task automatic test_mismatch;
    int base, obase;
    logic ack [3];
    base = wr_cnt;
    obase = oe_cnt;
    i2c_start;
    put_byte(8'h40, ack[0]);
    put_byte(8'h06, ack[1]);
    put_byte(8'h12, ack[2]);
    i2c_stop; #(Q);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ack[i] !== 1'b1) begin miscompares++; $display("FAIL mismatch_ack%0d got %b want 1", i, ack[i]); end
    end
    vectors++; if (oe_cnt - obase !== 0) begin miscompares++; $display("FAIL mismatch_oe_cycles got %0d want 0", oe_cnt - obase); end
    vectors++; if (wr_cnt - base !== 0) begin miscompares++; $display("FAIL mismatch_writes got %0d want 0", wr_cnt - base); end
  endtask

  task automatic test_pair_toggle;
    int base;
    logic ack;
    logic [2:0] ea [3];
    logic [7:0] ed [3];
    ea = '{3'd3, 3'd2, 3'd3};
    ed = '{8'h11, 8'h22, 8'h33};
    base = wr_cnt;
    i2c_start;
    put_byte(8'hE8, ack);
    put_byte(8'h03, ack);
    put_byte(8'h11, ack);
    put_byte(8'h22, ack);
    put_byte(8'h33, ack);
    i2c_stop; #(Q);
    vectors++; if (wr_cnt - base !== 3) begin miscompares++; $display("FAIL toggle_count got %0d want 3", wr_cnt - base); end
    for (int i = 0; i < 3; i++) if (base + i < wr_cnt) begin
      vectors++;
      if (wr_a[base+i] !== ea[i] || wr_d[base+i] !== ed[i]) begin
        miscompares++; $display("FAIL toggle_entry%0d got (%0d,%h) want (%0d,%h)", i, wr_a[base+i], wr_d[base+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_partial_stop;
    int base;
    logic ack [2];
    base = wr_cnt;
    i2c_start;
    put_byte(8'hE8, ack[0]);
    put_byte(8'h04, ack[1]);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    i2c_stop; #(Q);
    vectors++; if (ack[0] !== 1'b0 || ack[1] !== 1'b0) begin miscompares++; $display("FAIL partial_acks got %b%b want 00", ack[0], ack[1]); end
    vectors++; if (wr_cnt - base !== 0) begin miscompares++; $display("FAIL partial_writes got %0d want 0", wr_cnt - base); end
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL partial_sda_oe got %b want 0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL partial_busy got %b want 0", busy); end
    vectors++; if (rif.reg_addr !== 3'd4) begin miscompares++; $display("FAIL partial_ptr got %0d want 4", rif.reg_addr); end
  endtask

  task automatic test_reset_mid_read;
    int base;
    logic ack [3];
    logic b;
    i2c_start;
    put_byte(8'hE8, ack[0]);
    put_byte(8'h00, ack[1]);
    i2c_start;
    put_byte(8'hE9, ack[2]);
    get_bit(b);  // MSB of 0xA5
    vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL midrd_bit7 got %b want 1", b); end
    vectors++; if (sda_oe !== 1'b1) begin miscompares++; $display("FAIL midrd_driving got %b want 1", sda_oe); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL midrd_release got %b want 0", sda_oe); end
    vectors++; if (rif.reg_addr !== 3'd0) begin miscompares++; $display("FAIL midrd_ptr got %0d want 0", rif.reg_addr); end
    #(Q - 1);
    reset_n = 1'b1;
    #(Q);
    base = wr_cnt;
    i2c_start;
    put_byte(8'hE8, ack[0]);
    put_byte(8'h02, ack[1]);
    put_byte(8'h5A, ack[2]);
    i2c_stop; #(Q);
    vectors++; if (ack[0] !== 1'b0 || ack[1] !== 1'b0 || ack[2] !== 1'b0) begin
      miscompares++; $display("FAIL postrst_acks got %b%b%b want 000", ack[0], ack[1], ack[2]);
    end
    vectors++; if (wr_cnt - base !== 1) begin miscompares++; $display("FAIL postrst_count got %0d want 1", wr_cnt - base); end
    if (base < wr_cnt) begin
      vectors++;
      if (wr_a[base] !== 3'd2 || wr_d[base] !== 8'h5A) begin
        miscompares++; $display("FAIL postrst_entry got (%0d,%h) want (2,5a)", wr_a[base], wr_d[base]);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    scl      = 1'b1;
    ctrl_sda = 1'b1;
    a0       = 1'b0;
    a1       = 1'b0;
    rd_mem   = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    #2;  // keep all bench actions off clock edges
    test_reset;
    test_write;
    test_read;
    test_mismatch;
    test_pair_toggle;
    test_partial_stop;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
